mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 31 +++
 rtl/mem_responder_lfsr8.sv | 24 ++
 rtl/mem_responder.sv | 244 ++++++++++++++++++++++++
 tb/tb_mem_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder: response codes,
// channel state encodings, default base address and LFSR seed.
package mem_responder_pkg;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;
    localparam logic [7:0]  LFSR_SEED    = 8'hA5;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // True when addr falls inside [base, base + 4*depth); 34-bit compare avoids wrap.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] depth);
        logic [32:0] off_s;
        off_s = {1'b0, addr} - {1'b0, base};
        return (off_s[32] == 1'b0) && ({1'b0, off_s} < {depth, 2'b00});
    endfunction

endpackage

// File: rtl/mem_responder_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used as the
// random response-delay source.
module lfsr8
    import mem_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    logic feedback_s;

    assign feedback_s = q[7] ^ q[5] ^ q[4] ^ q[3];

    // Shift register: reloads the seed in reset, otherwise advances every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[6:0], feedback_s};
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-backed AXI-lite style responder with independent read and write
// channels, configurable fixed or pseudo-random response latency.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE        = DEFAULT_BASE,
    parameter int unsigned RAND_DELAY  = 0,
    parameter int unsigned FIXED_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] mem_r [DEPTH];
    logic [7:0]  lfsr_s;
    logic [1:0]  delay_s;
    logic        unused_lfsr_s;

    lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_s)
    );

    assign delay_s       = (RAND_DELAY != 0) ? lfsr_s[1:0] : 2'(FIXED_DELAY);
    assign unused_lfsr_s = ^lfsr_s[7:2];

    // ---------------- read channel ----------------
    rd_state_t        r_state_r, r_state_s;
    logic [1:0]       r_cnt_r, r_cnt_s;
    logic [31:0]      r_addr_r;
    logic [31:0]      rdata_r;
    logic [1:0]       rresp_r;
    logic             r_load_s;
    logic             ar_fire_s;
    logic [31:0]      rd_addr_s;
    logic             rd_ok_s;
    logic [IDX_W-1:0] rd_idx_s;

    assign arready   = (r_state_r == R_IDLE);
    assign rvalid    = (r_state_r == R_RESP);
    assign rdata     = rdata_r;
    assign rresp     = rresp_r;
    assign ar_fire_s = arvalid && arready;
    // A zero-delay read samples the array on the AR edge itself, before r_addr_r is loaded.
    assign rd_addr_s = (r_state_r == R_IDLE) ? araddr : r_addr_r;
    assign rd_ok_s   = addr_in_range(rd_addr_s, BASE, 32'(DEPTH));
    assign rd_idx_s  = IDX_W'((rd_addr_s - BASE) >> 2);

    // Read next-state: idle -> wait (d cycles) -> respond until rready.
    always_comb begin
        r_state_s = r_state_r;
        r_cnt_s   = r_cnt_r;
        r_load_s  = 1'b0;
        case (r_state_r)
            R_IDLE: begin
                if (ar_fire_s) begin
                    if (delay_s == 2'd0) begin
                        r_state_s = R_RESP;
                        r_load_s  = 1'b1;
                    end else begin
                        r_state_s = R_WAIT;
                        r_cnt_s   = delay_s - 2'd1;
                    end
                end else begin
                    r_state_s = R_IDLE;
                end
            end
            R_WAIT: begin
                if (r_cnt_r == 2'd0) begin
                    r_state_s = R_RESP;
                    r_load_s  = 1'b1;
                end else begin
                    r_cnt_s = r_cnt_r - 2'd1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    r_state_s = R_IDLE;
                end else begin
                    r_state_s = R_RESP;
                end
            end
            default: begin
                r_state_s = R_IDLE;
                r_cnt_s   = 2'd0;
            end
        endcase
    end

    // Read state, address latch and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_r <= R_IDLE;
            r_cnt_r   <= 2'd0;
            r_addr_r  <= 32'd0;
            rdata_r   <= 32'd0;
            rresp_r   <= RESP_OKAY;
        end else begin
            r_state_r <= r_state_s;
            r_cnt_r   <= r_cnt_s;
            if (ar_fire_s) begin
                r_addr_r <= araddr;
            end
            if (r_load_s) begin
                rdata_r <= rd_ok_s ? mem_r[rd_idx_s] : 32'd0;
                rresp_r <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // ---------------- write channel ----------------
    wr_state_t        w_state_r, w_state_s;
    logic [1:0]       w_cnt_r, w_cnt_s;
    logic             aw_got_r, w_got_r;
    logic [31:0]      awaddr_r, wdata_r;
    logic [3:0]       wstrb_r;
    logic [1:0]       bresp_r;
    logic             aw_fire_s, w_fire_s, b_fire_s;
    logic             w_commit_s;
    logic [31:0]      wr_addr_s, wr_data_s;
    logic [3:0]       wr_strb_s;
    logic             wr_ok_s;
    logic [IDX_W-1:0] wr_idx_s;

    assign awready    = (w_state_r == W_IDLE) && !aw_got_r;
    assign wready     = (w_state_r == W_IDLE) && !w_got_r;
    assign bvalid     = (w_state_r == W_RESP);
    assign bresp      = bresp_r;
    assign aw_fire_s  = awvalid && awready;
    assign w_fire_s   = wvalid && wready;
    assign b_fire_s   = bvalid && bready;
    assign wr_addr_s  = aw_got_r ? awaddr_r : awaddr;
    assign wr_data_s  = w_got_r ? wdata_r : wdata;
    assign wr_strb_s  = w_got_r ? wstrb_r : wstrb;
    assign wr_ok_s    = addr_in_range(wr_addr_s, BASE, 32'(DEPTH));
    assign wr_idx_s   = IDX_W'((wr_addr_s - BASE) >> 2);

    // Write next-state: collect AW and W in any order, wait d cycles, commit, respond.
    always_comb begin
        w_state_s  = w_state_r;
        w_cnt_s    = w_cnt_r;
        w_commit_s = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if ((aw_got_r || aw_fire_s) && (w_got_r || w_fire_s)) begin
                    if (delay_s == 2'd0) begin
                        w_state_s  = W_RESP;
                        w_commit_s = 1'b1;
                    end else begin
                        w_state_s = W_WAIT;
                        w_cnt_s   = delay_s - 2'd1;
                    end
                end else begin
                    w_state_s = W_IDLE;
                end
            end
            W_WAIT: begin
                if (w_cnt_r == 2'd0) begin
                    w_state_s  = W_RESP;
                    w_commit_s = 1'b1;
                end else begin
                    w_cnt_s = w_cnt_r - 2'd1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_s = W_IDLE;
                end else begin
                    w_state_s = W_RESP;
                end
            end
            default: begin
                w_state_s = W_IDLE;
                w_cnt_s   = 2'd0;
            end
        endcase
    end

    // Write state, captured AW/W payloads and B response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_r <= W_IDLE;
            w_cnt_r   <= 2'd0;
            aw_got_r  <= 1'b0;
            w_got_r   <= 1'b0;
            awaddr_r  <= 32'd0;
            wdata_r   <= 32'd0;
            wstrb_r   <= 4'd0;
            bresp_r   <= RESP_OKAY;
        end else begin
            w_state_r <= w_state_s;
            w_cnt_r   <= w_cnt_s;
            if (aw_fire_s) begin
                aw_got_r <= 1'b1;
                awaddr_r <= awaddr;
            end else if (b_fire_s) begin
                aw_got_r <= 1'b0;
            end
            if (w_fire_s) begin
                w_got_r <= 1'b1;
                wdata_r <= wdata;
                wstrb_r <= wstrb;
            end else if (b_fire_s) begin
                w_got_r <= 1'b0;
            end
            if (w_commit_s) begin
                bresp_r <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Backing store: byte-strobed commit, never cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && w_commit_s && wr_ok_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb_s[b]) begin
                    mem_r[wr_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench: fixed-delay instance against an array model,
// plus a random-delay instance whose latency is predicted from an LFSR model.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    logic [31:0] r2_araddr, r2_rdata, r2_awaddr, r2_wdata;
    logic        r2_arvalid, r2_arready, r2_rvalid, r2_rready;
    logic [1:0]  r2_rresp, r2_bresp;
    logic        r2_awvalid, r2_awready, r2_wvalid, r2_wready, r2_bvalid, r2_bready;
    logic [3:0]  r2_wstrb;

    mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .RAND_DELAY(0), .FIXED_DELAY(1)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .RAND_DELAY(1), .FIXED_DELAY(1)) dut_rnd (
        .clk(clk), .rst(rst),
        .araddr(r2_araddr), .arvalid(r2_arvalid), .arready(r2_arready),
        .rdata(r2_rdata), .rresp(r2_rresp), .rvalid(r2_rvalid), .rready(r2_rready),
        .awaddr(r2_awaddr), .awvalid(r2_awvalid), .awready(r2_awready),
        .wdata(r2_wdata), .wstrb(r2_wstrb), .wvalid(r2_wvalid), .wready(r2_wready),
        .bresp(r2_bresp), .bvalid(r2_bvalid), .bready(r2_bready)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;
    logic [31:0] model_mem [DEPTH];
    logic [7:0]  model_lfsr;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded in reset, stepping every edge.
    always @(posedge clk) begin
        model_lfsr <= rst ? 8'hA5 : {model_lfsr[6:0], model_lfsr[7] ^ model_lfsr[5] ^ model_lfsr[4] ^ model_lfsr[3]};
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        logic [63:0] a64, lo, hi;
        a64 = {32'd0, a};
        lo  = {32'd0, BASE};
        hi  = lo + 64'(4 * DEPTH);
        return (a64 >= lo) && (a64 < hi);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic do_read(input logic [31:0] addr, input int hold);
        int n;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        @(negedge clk);
        check_val("arready_idle", 32'(arready), 32'd1);
        araddr = addr; arvalid = 1'b1;
        @(posedge clk); #1 arvalid = 1'b0; araddr = $urandom();
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 16);
        check_val("rd_latency", n, 32'd2);
        exp_d = in_rng(addr) ? model_mem[widx(addr)] : 32'd0;
        exp_r = in_rng(addr) ? 2'b00 : 2'b10;
        check_val("rdata", rdata, exp_d);
        check_val("rresp", 32'(rresp), 32'(exp_r));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("rvalid_hold", 32'(rvalid), 32'd1);
            check_val("rdata_hold", rdata, exp_d);
        end
        rready = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
    endtask

    // order: 0 = same edge, 1 = AW first, 2 = W first; gap = idle cycles between.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int order, input int gap, input int hold);
        int n;
        logic [1:0] exp_r;
        @(negedge clk);
        if (order == 0) begin
            awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
            @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
        end else if (order == 1) begin
            awaddr = addr; awvalid = 1'b1;
            @(posedge clk); #1 awvalid = 1'b0;
            for (int i = 0; i <= gap; i++) begin
                @(negedge clk);
                check_val("awready_low", 32'(awready), 32'd0);
                check_val("wready_open", 32'(wready), 32'd1);
            end
            wdata = data; wstrb = strb; wvalid = 1'b1;
            @(posedge clk); #1 wvalid = 1'b0;
        end else begin
            wdata = data; wstrb = strb; wvalid = 1'b1;
            @(posedge clk); #1 wvalid = 1'b0;
            for (int i = 0; i <= gap; i++) begin
                @(negedge clk);
                check_val("wready_low", 32'(wready), 32'd0);
                check_val("awready_open", 32'(awready), 32'd1);
            end
            awaddr = addr; awvalid = 1'b1;
            @(posedge clk); #1 awvalid = 1'b0;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!bvalid && n < 16);
        check_val("wr_latency", n, 32'd2);
        exp_r = in_rng(addr) ? 2'b00 : 2'b10;
        check_val("bresp", 32'(bresp), 32'(exp_r));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("bresp_hold", 32'(bresp), 32'(exp_r));
            check_val("bvalid_hold", 32'(bvalid), 32'd1);
        end
        bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        if (in_rng(addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model_mem[widx(addr)][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic do_collide(input logic [31:0] addr, input logic [31:0] data);
        int n;
        logic [31:0] old;
        old = model_mem[widx(addr)];
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1 arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(rvalid && bvalid) && n < 16);
        check_val("coll_latency", n, 32'd2);
        check_val("coll_rdata_old", rdata, old);
        check_val("coll_bresp", 32'(bresp), 32'd0);
        rready = 1'b1; bready = 1'b1;
        @(posedge clk); #1 rready = 1'b0; bready = 1'b0;
        model_mem[widx(addr)] = data;
        do_read(addr, 0);
    endtask

    task automatic rnd_read2();
        int n;
        logic [7:0] lf;
        @(negedge clk);
        lf = model_lfsr;
        check_val("r2_arready", 32'(r2_arready), 32'd1);
        r2_araddr = BASE - 32'd4; r2_arvalid = 1'b1;
        @(posedge clk); #1 r2_arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!r2_rvalid && n < 16);
        check_val("r2_latency", n, 32'(lf[1:0]) + 32'd1);
        check_val("r2_rdata", r2_rdata, 32'd0);
        check_val("r2_rresp", 32'(r2_rresp), 32'd2);
        @(posedge clk); #1;
    endtask

    logic [31:0] oob_list [5];

    initial begin
        logic [31:0] a;
        oob_list[0] = BASE - 32'd4;
        oob_list[1] = BASE + 32'(4 * DEPTH);
        oob_list[2] = 32'h0000_0000;
        oob_list[3] = 32'hFFFF_FFFC;
        oob_list[4] = BASE + 32'(4 * DEPTH) + 32'h100;

        rst = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        r2_araddr = '0; r2_arvalid = 1'b0; r2_rready = 1'b1;
        r2_awaddr = '0; r2_awvalid = 1'b0; r2_wdata = '0; r2_wstrb = '0; r2_wvalid = 1'b0; r2_bready = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_arready", 32'(arready), 32'd1);
        check_val("rst_awready", 32'(awready), 32'd1);
        check_val("rst_wready", 32'(wready), 32'd1);
        check_val("rst_rvalid", 32'(rvalid), 32'd0);
        check_val("rst_bvalid", 32'(bvalid), 32'd0);
        check_val("rst_rdata", rdata, 32'd0);
        check_val("rst_rresp", 32'(rresp), 32'd0);
        check_val("rst_bresp", 32'(bresp), 32'd0);

        // Random-delay instance first, while the LFSR sequence is still fresh.
        for (int i = 0; i < 10; i++) rnd_read2();

        for (int i = 0; i < int'(DEPTH); i++) do_write(BASE + 32'(4 * i), $urandom(), 4'hF, 0, 0, 0);

        do_write(BASE, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        do_read(BASE, 0);
        do_write(BASE + 32'd4, 32'd0, 4'hF, 1, 0, 0);
        do_write(BASE + 32'd4, 32'h1122_3344, 4'b0101, 0, 0, 1);
        do_read(BASE + 32'd4, 0);
        do_read(BASE - 32'd4, 0);
        do_write(BASE + 32'(4 * DEPTH), 32'hCAFE_F00D, 4'hF, 0, 0, 0);
        do_read(BASE, 0);
        do_write(BASE + 32'd8, 32'h5A5A_A5A5, 4'hF, 2, 2, 0);
        do_read(BASE + 32'd8, 5);
        do_collide(BASE + 32'd12, 32'h0BAD_CAFE);

        // Reset while a read sits in R_WAIT.
        @(negedge clk);
        araddr = BASE; arvalid = 1'b1;
        @(posedge clk); #1 arvalid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_val("rst_mid_arready", 32'(arready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("rst_mid_rvalid", 32'(rvalid), 32'd0);
        end

        // Reset while a write sits in W_WAIT: nothing may be committed.
        @(negedge clk);
        awaddr = BASE + 32'd20; awvalid = 1'b1; wdata = ~model_mem[5]; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_mid_bvalid", 32'(bvalid), 32'd0);
        end
        do_read(BASE + 32'd20, 0);

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 8) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            else a = oob_list[$urandom_range(0, 4)];
            if ($urandom_range(0, 1) == 0) do_read(a, int'($urandom_range(0, 3)));
            else do_write(a, $urandom(), 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < int'(DEPTH); i++) do_read(BASE + 32'(4 * i), 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
